// File: rtl/dmem_arbiter_if.sv
// Request/grant/read-response bundle between one memory master and the data-memory arbiter.
// The master drives the request fields and the arbiter returns the grant and read data.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port data memory with 1-cycle registered reads.
// One access is granted per cycle, either round-robin or master-0 priority with anti-starvation.
module dmem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // last_q: 0 = master 0 was granted last, 1 = master 1 was granted last
    logic              last_q, last_d;
    logic [7:0]        starve_q, starve_d;
    logic [1:0]        rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;

    logic              m1_wins_tie;
    logic              gnt0;
    logic              gnt1;

    // Arbitration: only the tie-break differs between the two modes.
    always_comb begin
        m1_wins_tie = (FIXED_PRIO != 0) ? (starve_q == LIMIT) : ~last_q;
        gnt0        = rst_n & m0.req & (~m1.req | ~m1_wins_tie);
        gnt1        = rst_n & m1.req & (~m0.req |  m1_wins_tie);
    end

    // Memory port mux; the address is held while idle so the memory sees a stable bus.
    always_comb begin
        mem_addr    = addr_hold_q;
        mem_data_in = '0;
        mem_we      = 1'b0;
        if (gnt0) begin
            mem_addr    = m0.addr;
            mem_data_in = m0.wdata;
            mem_we      = m0.we;
        end else if (gnt1) begin
            mem_addr    = m1.addr;
            mem_data_in = m1.wdata;
            mem_we      = m1.we;
        end
    end

    always_comb begin
        last_d      = last_q;
        starve_d    = starve_q;
        rd_sel_d    = {gnt1 & ~m1.we, gnt0 & ~m0.we};
        addr_hold_d = mem_addr;

        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end

        // Counts cycles master 1 has waited with a pending request, saturating at the limit.
        if (!m1.req || gnt1) begin
            starve_d = '0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q      <= 1'b1;
            starve_q    <= '0;
            rd_sel_q    <= 2'b00;
            addr_hold_q <= '0;
        end else begin
            last_q      <= last_d;
            starve_q    <= starve_d;
            rd_sel_q    <= rd_sel_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    // A response still in flight when reset asserts is suppressed immediately.
    assign m0.gnt    = gnt0;
    assign m0.rvalid = rd_sel_q[0] & rst_n;
    assign m0.rdata  = mem_data_out;
    assign m1.gnt    = gnt1;
    assign m1.rvalid = rd_sel_q[1] & rst_n;
    assign m1.rdata  = mem_data_out;

    a_one_grant : assert property (@(posedge clk) !(gnt0 && gnt1));
    a_no_we_idle : assert property (@(posedge clk) (mem_we |-> (gnt0 || gnt1)));
endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter: a round-robin and a fixed-priority instance see the
// same stimulus; read responses are tracked with an expected-data scoreboard.
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          r0, w0, r1, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rr_m0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rr_m1 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp_m0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp_m1 ();

    assign rr_m0.req = r0; assign rr_m0.we = w0; assign rr_m0.addr = a0; assign rr_m0.wdata = d0;
    assign rr_m1.req = r1; assign rr_m1.we = w1; assign rr_m1.addr = a1; assign rr_m1.wdata = d1;
    assign fp_m0.req = r0; assign fp_m0.we = w0; assign fp_m0.addr = a0; assign fp_m0.wdata = d0;
    assign fp_m1.req = r1; assign fp_m1.we = w1; assign fp_m1.addr = a1; assign fp_m1.wdata = d1;

    logic [AW-1:0] rr_maddr, fp_maddr;
    logic [DW-1:0] rr_mdin, fp_mdin, rr_mdout, fp_mdout;
    logic          rr_mwe, fp_mwe;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .STARVE_LIMIT(4)) dut_rr (
        .clk(clk), .rst_n(rst_n), .m0(rr_m0), .m1(rr_m1),
        .mem_addr(rr_maddr), .mem_data_in(rr_mdin), .mem_we(rr_mwe), .mem_data_out(rr_mdout)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .STARVE_LIMIT(4)) dut_fp (
        .clk(clk), .rst_n(rst_n), .m0(fp_m0), .m1(fp_m1),
        .mem_addr(fp_maddr), .mem_data_in(fp_mdin), .mem_we(fp_mwe), .mem_data_out(fp_mdout)
    );

    function automatic logic [31:0] init_val(input logic [9:0] a);
        case (a)
            10'd256: return 32'h0000_07D1;
            10'd257: return 32'h0000_0FA1;
            10'd258: return 32'h0000_1389;
            default: return {16'hA5A5, 6'd0, a};
        endcase
    endfunction

    // Memory models: registered read, write and read never in the same cycle.
    logic [DW-1:0] rr_mem [1024];
    bit            rr_wr  [1024];
    logic [DW-1:0] fp_mem [1024];
    bit            fp_wr  [1024];

    always @(posedge clk) begin
        if (rr_mwe) begin
            rr_mem[rr_maddr] <= rr_mdin;
            rr_wr[rr_maddr]  <= 1'b1;
        end else begin
            rr_mdout <= rr_wr[rr_maddr] ? rr_mem[rr_maddr] : init_val(rr_maddr);
        end
    end

    always @(posedge clk) begin
        if (fp_mwe) begin
            fp_mem[fp_maddr] <= fp_mdin;
            fp_wr[fp_maddr]  <= 1'b1;
        end else begin
            fp_mdout <= fp_wr[fp_maddr] ? fp_mem[fp_maddr] : init_val(fp_maddr);
        end
    end

    typedef struct {
        logic        rst_n;
        logic        r0, w0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic [1:0]  g_rr;
        logic [1:0]  g_fp;
    } vec_t;

    typedef struct {
        int          inst;
        int          due;
        int          m;
        logic [31:0] data;
    } sb_t;

    vec_t        vecs [$];
    sb_t         sb_q [$];
    logic [31:0] exp_mem [2][1024];
    logic [9:0]  last_addr [2];
    bit          last_ok [2];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic q0, input logic we0, input int ad0, input logic [31:0] wd0,
                       input logic q1, input logic we1, input int ad1, input logic [31:0] wd1,
                       input logic [1:0] grr, input logic [1:0] gfp);
        vec_t v;
        v.rst_n = rs;
        v.r0 = q0; v.w0 = we0; v.a0 = 10'(ad0); v.d0 = wd0;
        v.r1 = q1; v.w1 = we1; v.a1 = 10'(ad1); v.d1 = wd1;
        v.g_rr = grr; v.g_fp = gfp;
        vecs.push_back(v);
    endtask

    task automatic check_inst(input int inst, input vec_t v, input logic [1:0] g_exp,
                              input logic g0, input logic g1, input logic rv0, input logic rv1,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input logic mwe, input logic [9:0] maddr, input logic [31:0] mdin);
        string       p;
        logic [1:0]  rv_exp;
        logic [31:0] rd_exp;
        logic        ex_we;
        logic [31:0] ex_din;
        logic [9:0]  ex_addr;
        p = (inst == 0) ? "rr" : "fp";
        rv_exp = 2'b00;
        rd_exp = '0;

        chk({p, "_gnt"}, {30'd0, g1, g0}, {30'd0, g_exp});
        ex_we = (g_exp[0] & v.w0) | (g_exp[1] & v.w1);
        chk({p, "_mem_we"}, {31'd0, mwe}, {31'd0, ex_we});
        ex_din = g_exp[0] ? v.d0 : (g_exp[1] ? v.d1 : 32'd0);
        chk({p, "_mem_data_in"}, mdin, ex_din);

        if (g_exp != 2'b00) begin
            ex_addr = g_exp[0] ? v.a0 : v.a1;
            chk({p, "_mem_addr"}, {22'd0, maddr}, {22'd0, ex_addr});
            last_addr[inst] = ex_addr;
            last_ok[inst]   = 1'b1;
        end else if (last_ok[inst] && v.rst_n) begin
            chk({p, "_mem_addr_hold"}, {22'd0, maddr}, {22'd0, last_addr[inst]});
        end
        if (!v.rst_n) last_ok[inst] = 1'b0;

        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].inst == inst && sb_q[i].due == cyc) begin
                if (v.rst_n) begin
                    rv_exp[sb_q[i].m] = 1'b1;
                    rd_exp = sb_q[i].data;
                end
                sb_q.delete(i);
                break;
            end
        end
        chk({p, "_rvalid"}, {30'd0, rv1, rv0}, {30'd0, rv_exp});
        if (rv_exp[0]) chk({p, "_m0_rdata"}, rd0, rd_exp);
        if (rv_exp[1]) chk({p, "_m1_rdata"}, rd1, rd_exp);

        for (int k = 0; k < 2; k++) begin
            if (g_exp[k]) begin
                logic        kwe;
                logic [9:0]  ka;
                logic [31:0] kd;
                sb_t         e;
                kwe = (k == 0) ? v.w0 : v.w1;
                ka  = (k == 0) ? v.a0 : v.a1;
                kd  = (k == 0) ? v.d0 : v.d1;
                if (kwe) begin
                    exp_mem[inst][ka] = kd;
                end else begin
                    e.inst = inst; e.due = cyc + 1; e.m = k; e.data = exp_mem[inst][ka];
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int a = 0; a < 1024; a++) begin
            exp_mem[0][a] = init_val(10'(a));
            exp_mem[1][a] = init_val(10'(a));
        end
        last_ok[0] = 1'b0;
        last_ok[1] = 1'b0;
        rst_n = 1'b0;
        r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
        r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;

        //   rst q0 w0 a0   d0            q1 w1 a1   d1            rr     fp
        add(0, 1, 0, 256, 0,            0, 0, 0,   0,            2'b00, 2'b00); // request gated in reset
        add(0, 0, 0, 0,   0,            0, 0, 0,   0,            2'b00, 2'b00);
        add(1, 1, 0, 256, 0,            0, 0, 0,   0,            2'b01, 2'b01); // T1
        add(1, 0, 0, 0,   0,            0, 0, 0,   0,            2'b00, 2'b00);
        add(0, 0, 0, 0,   0,            0, 0, 0,   0,            2'b00, 2'b00);
        add(1, 1, 0, 257, 0,            1, 0, 258, 0,            2'b01, 2'b01); // T2 tie
        add(1, 0, 0, 0,   0,            1, 0, 258, 0,            2'b10, 2'b10);
        add(1, 0, 0, 0,   0,            0, 0, 0,   0,            2'b00, 2'b00);
        add(1, 1, 0, 260, 0,            1, 0, 261, 0,            2'b01, 2'b01); // tie after m1 grant
        add(1, 1, 0, 262, 0,            1, 0, 261, 0,            2'b10, 2'b01); // modes diverge
        add(1, 0, 0, 0,   0,            0, 0, 0,   0,            2'b00, 2'b00);
        add(1, 0, 0, 0,   0,            1, 1, 259, 32'hDEADBEEF, 2'b10, 2'b10); // T3 write
        add(1, 1, 0, 259, 0,            0, 0, 0,   0,            2'b01, 2'b01);
        for (int i = 0; i < 11; i++)                                             // T6 idle
            add(1, 0, 0, 0, 0,          0, 0, 0,   0,            2'b00, 2'b00);
        add(1, 1, 0, 256, 0,            0, 0, 0,   0,            2'b01, 2'b01); // T5 read then reset
        add(0, 0, 0, 0,   0,            0, 0, 0,   0,            2'b00, 2'b00);
        add(1, 1, 0, 257, 0,            1, 0, 258, 0,            2'b01, 2'b01);
        add(1, 0, 0, 0,   0,            1, 0, 258, 0,            2'b10, 2'b10);
        add(1, 0, 0, 0,   0,            0, 0, 0,   0,            2'b00, 2'b00);
        for (int i = 0; i < 10; i++)                                             // T4 continuous
            add(1, 1, 0, 300 + i, 0,    1, 0, 400 + i, 0,
                (i % 2 == 0) ? 2'b01 : 2'b10, (i % 5 == 4) ? 2'b10 : 2'b01);
        add(1, 0, 0, 0,   0,            0, 0, 0,   0,            2'b00, 2'b00);
        add(1, 0, 0, 0,   0,            0, 0, 0,   0,            2'b00, 2'b00);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            r0 = vecs[i].r0; w0 = vecs[i].w0; a0 = vecs[i].a0; d0 = vecs[i].d0;
            r1 = vecs[i].r1; w1 = vecs[i].w1; a1 = vecs[i].a1; d1 = vecs[i].d1;
            #2;
            check_inst(0, vecs[i], vecs[i].g_rr, rr_m0.gnt, rr_m1.gnt, rr_m0.rvalid, rr_m1.rvalid,
                       rr_m0.rdata, rr_m1.rdata, rr_mwe, rr_maddr, rr_mdin);
            check_inst(1, vecs[i], vecs[i].g_fp, fp_m0.gnt, fp_m1.gnt, fp_m0.rvalid, fp_m1.rvalid,
                       fp_m0.rdata, fp_m1.rdata, fp_mwe, fp_maddr, fp_mdin);
            $display("vec %0d rst_n=%0b req=%0b%0b rr_gnt=%0b%0b fp_gnt=%0b%0b", i, rst_n, r1, r0,
                     rr_m1.gnt, rr_m0.gnt, fp_m1.gnt, fp_m0.gnt);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("scoreboard_drained", sb_q.size(), 0);

        // Fixed priority: m1 holds a write while m0 streams reads; forced grant on the 5th cycle.
        r0 = 1'b1; w0 = 1'b0; a0 = 10'd300;
        r1 = 1'b1; w1 = 1'b1; a1 = 10'd500; d1 = 32'hCAFE_F00D;
        n = 0;
        while (n < 20) begin
            #2;
            if (fp_m1.gnt) break;
            chk("fp_m0_streams", {31'd0, fp_m0.gnt}, 32'd1);
            @(posedge clk);
            cyc++;
            @(negedge clk);
            n++;
        end
        chk("fp_starve_wait", n, 4);
        chk("fp_forced_write_we", {31'd0, fp_mwe}, 32'd1);
        $display("starve sequence: m1 granted after %0d waiting cycles", n);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        r1 = 1'b0; w1 = 1'b0;
        a0 = 10'd500;
        #2;
        chk("fp_write_no_rvalid", {30'd0, fp_m1.rvalid, fp_m0.rvalid}, 32'd0);
        chk("fp_read_after_write_gnt", {31'd0, fp_m0.gnt}, 32'd1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        r0 = 1'b0;
        #2;
        chk("fp_read_after_write_rvalid", {31'd0, fp_m0.rvalid}, 32'd1);
        chk("fp_read_after_write_rdata", fp_m0.rdata, 32'hCAFE_F00D);
        $display("read-after-write: rdata=0x%08h", fp_m0.rdata);
        @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
